// File: rtl/vga_fb_pkg.sv
// vga_fb_pkg: shared types and constants for the frame-buffer port arbiter.
package vga_fb_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        ACK   = 2'd2
    } wr_state_e;
    localparam int FB_DEPTH_1440x900 = 1440 * 900;
    localparam int DEF_ADDR_W = 21;
    localparam int DEF_DATA_W = 16;
endpackage

// File: rtl/vga_fb_scan_addr.sv
// vga_fb_scan_addr: linear scan-out address, cleared on VSYNC rising edge, wraps at FB_DEPTH.
module vga_fb_scan_addr
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int FB_DEPTH = FB_DEPTH_1440x900
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic              Ready_Sig,
    input  logic              VSYNC_Sig,
    output logic [ADDR_W-1:0] scan_addr
);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FB_DEPTH - 1);
    logic              vs_q;
    logic [ADDR_W-1:0] addr_q, addr_d;
    // A frame start overrides any increment in the same cycle.
    always_comb addr_d = (VSYNC_Sig && !vs_q) ? '0 :
                         !Ready_Sig           ? addr_q :
                         (addr_q == LAST)     ? '0 : addr_q + 1'b1;
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_q   <= 1'b0;
            addr_q <= '0;
        end else begin
            vs_q   <= VSYNC_Sig;
            addr_q <= addr_d;
        end
    end
    assign scan_addr = addr_q;
endmodule

// File: rtl/vga_fb_port_arbiter.sv
// vga_fb_port_arbiter: shares a single-port frame buffer between VGA scan-out and a pixel writer.
// Scan-out reads own the RAM during active video; writes are issued only in blanking.
module vga_fb_port_arbiter
    import vga_fb_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int DATA_W   = DEF_DATA_W,
    parameter int FB_DEPTH = FB_DEPTH_1440x900
) (
    input  logic              vga_clk,
    input  logic              rst_n,
    input  logic              Ready_Sig,
    input  logic              VSYNC_Sig,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid
);
    logic [ADDR_W-1:0] scan_addr;
    wr_state_e         state_q;
    logic [ADDR_W-1:0] wa_q;
    logic [DATA_W-1:0] wd_q;
    logic              rd_v1_q, pix_valid_q;
    logic [DATA_W-1:0] pix_data_q;
    logic              write_now;

    vga_fb_scan_addr #(
        .ADDR_W   (ADDR_W),
        .FB_DEPTH (FB_DEPTH)
    ) u_scan (
        .vga_clk   (vga_clk),
        .rst_n     (rst_n),
        .Ready_Sig (Ready_Sig),
        .VSYNC_Sig (VSYNC_Sig),
        .scan_addr (scan_addr)
    );

    // Active video always wins the port; a latched write simply waits for blanking.
    assign write_now = (state_q == WRITE) && !Ready_Sig;
    assign mem_we    = write_now;
    assign mem_addr  = write_now ? wa_q : scan_addr;
    assign mem_wdata = wd_q;
    assign wr_ack    = (state_q == ACK);

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wa_q    <= '0;
            wd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: if (wr_req && !Ready_Sig) begin
                    wa_q    <= wr_addr;
                    wd_q    <= wr_data;
                    state_q <= WRITE;
                end
                WRITE:   state_q <= Ready_Sig ? WRITE : ACK;
                ACK:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Two-stage pipe matching the RAM's one-cycle read latency.
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1_q     <= 1'b0;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
        end else begin
            rd_v1_q     <= Ready_Sig;
            pix_valid_q <= rd_v1_q;
            pix_data_q  <= rd_v1_q ? mem_rdata : '0;
        end
    end
    assign pix_valid = pix_valid_q;
    assign pix_data  = pix_data_q;
endmodule
